// File: rtl/ptp_rtc_counter.sv
// IEEE 1588 real-time clock: 48-bit seconds, 30-bit ns, 32-bit fractional ns,
// with absolute load, signed offset adjust and a stretched pulse-per-second.
module ptp_rtc_counter #(
    parameter int unsigned NS_PER_SEC = 1_000_000_000,
    parameter int unsigned PPS_CYCLES = 16
) (
    input  logic        rtc_clk,
    input  logic        rst_sys_n,
    input  logic [7:0]  inc_ns_i,
    input  logic [31:0] inc_frac_i,
    input  logic        load_req_i,
    input  logic [47:0] load_sec_i,
    input  logic [29:0] load_ns_i,
    input  logic        adj_req_i,
    input  logic        adj_neg_i,
    input  logic [29:0] adj_ns_i,
    output logic        load_ack_o,
    output logic        adj_ack_o,
    output logic [47:0] sec_o,
    output logic [29:0] ns_o,
    output logic [31:0] frac_o,
    output logic        pps_o
);

    localparam logic [31:0] NS_MAX   = 32'(NS_PER_SEC - 1);
    localparam int          NS_S     = int'(NS_PER_SEC);
    localparam logic [7:0]  PPS_LOAD = 8'(PPS_CYCLES);

    logic [47:0] sec_q,  sec_d;
    logic [29:0] ns_q,   ns_d;
    logic [31:0] frac_q, frac_d;
    logic [7:0]  pps_cnt_q;
    logic        load_ack_q, adj_ack_q;
    logic        sec_carry;

    logic [32:0]        frac_sum;
    logic [31:0]        ns_inc;
    logic [31:0]        adj_mag;
    logic signed [31:0] ns_sum;

    // All ns arithmetic stays below 2^31, so a 32-bit signed sum covers both
    // the positive-adjust overflow and the negative-adjust borrow.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the if/else chain can infer a latch.
        sec_d     = sec_q;
        ns_d      = ns_q;
        frac_d    = frac_q;
        sec_carry = 1'b0;

        frac_sum = {1'b0, frac_q} + {1'b0, inc_frac_i};
        ns_inc   = {2'b0, ns_q} + {24'b0, inc_ns_i} + {31'b0, frac_sum[32]};
        adj_mag  = ({2'b0, adj_ns_i} > NS_MAX) ? NS_MAX : {2'b0, adj_ns_i};

        ns_sum = signed'(ns_inc);
        if (adj_req_i) begin
            ns_sum = adj_neg_i ? ns_sum - signed'(adj_mag) : ns_sum + signed'(adj_mag);
        end

        if (load_req_i) begin
            sec_d  = load_sec_i;
            ns_d   = ({2'b0, load_ns_i} > NS_MAX) ? 30'(NS_MAX) : load_ns_i;
            frac_d = '0;
        end else begin
            frac_d = frac_sum[31:0];
            if (ns_sum < 0) begin
                ns_d  = 30'(ns_sum + NS_S);
                sec_d = sec_q - 48'd1;
            end else if (ns_sum >= NS_S) begin
                ns_d      = 30'(ns_sum - NS_S);
                sec_d     = sec_q + 48'd1;
                sec_carry = 1'b1;
            end else begin
                ns_d = 30'(ns_sum);
            end
        end
    end

    always_ff @(posedge rtc_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            sec_q      <= '0;
            ns_q       <= '0;
            frac_q     <= '0;
            pps_cnt_q  <= '0;
            load_ack_q <= 1'b0;
            adj_ack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            sec_q      <= sec_d;
            ns_q       <= ns_d;
            frac_q     <= frac_d;
            load_ack_q <= load_req_i;
            adj_ack_q  <= adj_req_i & ~load_req_i;
            if (sec_carry) begin
                pps_cnt_q <= PPS_LOAD;
            end else if (pps_cnt_q != 8'd0) begin
                pps_cnt_q <= pps_cnt_q - 8'd1;
            end
        end
    end

    assign sec_o      = sec_q;
    assign ns_o       = ns_q;
    assign frac_o     = frac_q;
    assign load_ack_o = load_ack_q;
    assign adj_ack_o  = adj_ack_q;
    assign pps_o      = (pps_cnt_q != 8'd0);

endmodule

// File: tb/tb_ptp_rtc_counter.sv
// Self-checking bench for ptp_rtc_counter: directed scenarios plus randomized
// load/adjust/increment traffic against a seconds+nanoseconds arithmetic model.
module tb_ptp_rtc_counter;

    localparam longint NS       = 1_000_000_000;
    localparam int     PPS      = 16;
    localparam longint SEC_MASK = 64'h0000_FFFF_FFFF_FFFF;

    logic        rtc_clk = 1'b0;
    logic        rst_sys_n;
    logic [7:0]  inc_ns_i;
    logic [31:0] inc_frac_i;
    logic        load_req_i;
    logic [47:0] load_sec_i;
    logic [29:0] load_ns_i;
    logic        adj_req_i;
    logic        adj_neg_i;
    logic [29:0] adj_ns_i;
    logic        load_ack_o;
    logic        adj_ack_o;
    logic [47:0] sec_o;
    logic [29:0] ns_o;
    logic [31:0] frac_o;
    logic        pps_o;

    int n_checks = 0;
    int n_errors = 0;

    longint m_sec, m_ns, m_frac;
    int     m_pps;
    logic   m_load_ack, m_adj_ack;

    ptp_rtc_counter #(.NS_PER_SEC(1_000_000_000), .PPS_CYCLES(PPS)) dut (
        .rtc_clk    (rtc_clk),
        .rst_sys_n  (rst_sys_n),
        .inc_ns_i   (inc_ns_i),
        .inc_frac_i (inc_frac_i),
        .load_req_i (load_req_i),
        .load_sec_i (load_sec_i),
        .load_ns_i  (load_ns_i),
        .adj_req_i  (adj_req_i),
        .adj_neg_i  (adj_neg_i),
        .adj_ns_i   (adj_ns_i),
        .load_ack_o (load_ack_o),
        .adj_ack_o  (adj_ack_o),
        .sec_o      (sec_o),
        .ns_o       (ns_o),
        .frac_o     (frac_o),
        .pps_o      (pps_o)
    );

    always #5 rtc_clk = ~rtc_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_ns = 0; m_frac = 0; m_pps = 0;
        m_load_ack = 1'b0; m_adj_ack = 1'b0;
    endtask

    // Time advances as plain integer ns; whole seconds are normalised out and
    // a forward step across a second boundary starts the PPS pulse.
    task automatic model_step();
        longint fsum, delta, n, mag;
        bit     carry = 1'b0;
        if (load_req_i) begin
            m_sec  = longint'({16'b0, load_sec_i});
            m_ns   = (longint'({34'b0, load_ns_i}) > NS - 1) ? NS - 1 : longint'({34'b0, load_ns_i});
            m_frac = 0;
        end else begin
            fsum  = m_frac + longint'({32'b0, inc_frac_i});
            delta = longint'({56'b0, inc_ns_i}) + (fsum / 64'sd4294967296);
            m_frac = fsum % 64'sd4294967296;
            if (adj_req_i) begin
                mag = longint'({34'b0, adj_ns_i});
                if (mag > NS - 1) mag = NS - 1;
                delta = adj_neg_i ? delta - mag : delta + mag;
            end
            n = m_ns + delta;
            while (n >= NS) begin n -= NS; m_sec = (m_sec + 1) & SEC_MASK; carry = 1'b1; end
            while (n < 0)   begin n += NS; m_sec = (m_sec - 1) & SEC_MASK; end
            m_ns = n;
        end
        if (carry) m_pps = PPS;
        else if (m_pps > 0) m_pps--;
        m_load_ack = load_req_i;
        m_adj_ack  = adj_req_i && !load_req_i;
    endtask

    task automatic check_all();
        check("sec",      64'(sec_o),      64'(m_sec));
        check("ns",       64'(ns_o),       64'(m_ns));
        check("frac",     64'(frac_o),     64'(m_frac));
        check("pps",      64'(pps_o),      64'(m_pps != 0));
        check("load_ack", 64'(load_ack_o), 64'(m_load_ack));
        check("adj_ack",  64'(adj_ack_o),  64'(m_adj_ack));
    endtask

    // Inputs stay stable across the edge; the model consumes them there and
    // outputs are compared 1 ns later.
    task automatic tick();
        @(posedge rtc_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        load_req_i = 1'b0;
        adj_req_i  = 1'b0;
    endtask

    task automatic do_load(input logic [47:0] s, input logic [29:0] n);
        load_req_i = 1'b1; load_sec_i = s; load_ns_i = n;
        tick();
        idle();
    endtask

    initial begin
        int pps_len;
        rst_sys_n  = 1'b0;
        inc_ns_i   = 8'd8;
        inc_frac_i = '0;
        load_sec_i = '0; load_ns_i = '0;
        adj_neg_i  = 1'b0; adj_ns_i = '0;
        idle();
        model_reset();

        // 1: reset state, 10 cycles at 8 ns, then asynchronous reset mid-run
        repeat (3) @(posedge rtc_clk);
        #1;
        check_all();
        rst_sys_n = 1'b1;
        repeat (10) tick();
        check("t1_ns80", 64'(ns_o), 64'd80);
        check("t1_sec0", 64'(sec_o), 64'd0);
        #3 rst_sys_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_sys_n = 1'b1;

        // 2: load just before a second boundary; PPS lasts exactly PPS cycles
        do_load(48'd5, 30'd999_999_992);
        check("t2_ack", 64'(load_ack_o), 64'd1);
        check("t2_ns",  64'(ns_o), 64'd999_999_992);
        tick();
        check("t2_sec6", 64'(sec_o), 64'd6);
        check("t2_ns0",  64'(ns_o), 64'd0);
        pps_len = pps_o ? 1 : 0;
        repeat (20) begin
            tick();
            if (pps_o) pps_len++;
        end
        check("t2_pps_len", 64'(pps_len), 64'(PPS));

        // 3: fractional carry at the 6.4 ns increment
        inc_ns_i = 8'd0;
        do_load(48'd0, 30'd0);
        inc_ns_i = 8'd6; inc_frac_i = 32'h6666_6666;
        repeat (5) tick();
        check("t3_ns31",   64'(ns_o), 64'd31);
        check("t3_frac5",  64'(frac_o), 64'hFFFF_FFFE);
        tick();
        check("t3_ns38",   64'(ns_o), 64'd38);
        check("t3_frac6",  64'(frac_o), 64'h6666_6664);

        // 4: negative adjust borrows a second without PPS
        inc_ns_i = 8'd8; inc_frac_i = '0;
        do_load(48'd10, 30'd100);
        adj_req_i = 1'b1; adj_neg_i = 1'b1; adj_ns_i = 30'd200;
        tick();
        idle();
        check("t4_sec",  64'(sec_o), 64'd9);
        check("t4_ns",   64'(ns_o), 64'd999_999_908);
        check("t4_ack",  64'(adj_ack_o), 64'd1);
        check("t4_pps",  64'(pps_o), 64'd0);

        // 5: load wins over a simultaneous adjust; out-of-range load ns clamps
        adj_req_i = 1'b1; adj_neg_i = 1'b0; adj_ns_i = 30'd500;
        do_load(48'd3, 30'd0);
        check("t5_sec",      64'(sec_o), 64'd3);
        check("t5_ns",       64'(ns_o), 64'd0);
        check("t5_load_ack", 64'(load_ack_o), 64'd1);
        check("t5_adj_ack",  64'(adj_ack_o), 64'd0);
        do_load(48'd3, 30'h3FFF_FFFF);
        check("t5_clamp", 64'(ns_o), 64'd999_999_999);

        // 6: seconds wrap forward and backward
        do_load(48'hFFFF_FFFF_FFFF, 30'd999_999_999);
        tick();
        check("t6_sec0", 64'(sec_o), 64'd0);
        check("t6_ns7",  64'(ns_o), 64'd7);
        check("t6_pps",  64'(pps_o), 64'd1);
        inc_ns_i = 8'd0;
        do_load(48'd0, 30'd0);
        adj_req_i = 1'b1; adj_neg_i = 1'b1; adj_ns_i = 30'd1;
        tick();
        idle();
        check("t6_secmax", 64'(sec_o), 64'hFFFF_FFFF_FFFF);
        check("t6_nsmax",  64'(ns_o), 64'd999_999_999);

        // Randomized traffic, biased toward second boundaries and wraps
        repeat (3000) begin
            int r;
            r = int'($urandom_range(0, 3));
            inc_ns_i   = (r == 0) ? 8'd8 : (r == 1) ? 8'd6 : (r == 2) ? 8'd0 : 8'($urandom);
            inc_frac_i = (r == 1) ? 32'h6666_6666 : $urandom;
            load_req_i = ($urandom_range(0, 15) == 0);
            load_sec_i = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 1))
                                                     : {16'($urandom), $urandom};
            load_ns_i  = ($urandom_range(0, 1) == 0) ? 30'(999_999_999 - $urandom_range(0, 400))
                                                     : 30'($urandom);
            adj_req_i  = ($urandom_range(0, 7) == 0);
            adj_neg_i  = 1'($urandom);
            adj_ns_i   = ($urandom_range(0, 1) == 0) ? 30'($urandom_range(0, 1000)) : 30'($urandom);
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
